// File: rtl/mcpu_pkg.sv
// Shared opcodes, FSM state encoding and instruction field positions for the mcpu core.
package mcpu_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_LDI  = 4'h6;
   localparam logic [3:0] OP_LD   = 4'h7;
   localparam logic [3:0] OP_ST   = 4'h8;
   localparam logic [3:0] OP_BEQ  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_MUL  = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int IR_W    = 16;
   localparam int FIELD_W = 4;
   localparam int OP_LSB  = 12;
   localparam int RD_LSB  = 8;
   localparam int RS_LSB  = 4;
   localparam int RT_LSB  = 0;

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_HALT    = 3'd5
   } mcpu_state_e;

endpackage

// File: rtl/mcpu_if.sv
// Instruction-memory bus between the core (master) and its combinational ROM (slave).
interface mcpu_if #(parameter int PC_W = 8);
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_rdata;

   modport master (output imem_addr, input imem_rdata);
   modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/mcpu_alu.sv
// Combinational ALU for register and immediate ops; MUL exists only when MCPU_MUL_EN is defined.
// result_valid flags opcodes whose result is written back to the register file.
module mcpu_alu import mcpu_pkg::*; #(
   parameter int DATA_W = 16
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [7:0]        imm,
   output logic [DATA_W-1:0] result,
   output logic              result_valid
);

   always_comb begin
      result       = '0;
      result_valid = 1'b1;
      case (op)
         OP_ADD: result = a + b;
         OP_SUB: result = a - b;
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_LDI: result = DATA_W'(imm);
`ifdef MCPU_MUL_EN
         OP_MUL: result = a * b;
`endif
         default: result_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/mcpu_core.sv
// Parametrised multi-cycle CPU core with internal register file and DMEM; MCPU_MUL_EN enables MUL.
// state     | meaning
// S_FETCH   | IR <- ROM[pc], pc <- pc+1
// S_DECODE  | operands settle from the register file
// S_EXECUTE | latch ALU result, resolve BEQ/JMP, HALT retires here
// S_MEM     | LD latches DMEM into mdr, ST writes DMEM
// S_WB      | register write-back, retire
// S_HALT    | terminal until reset
module mcpu_core import mcpu_pkg::*; #(
   parameter int DATA_W     = 16,
   parameter int NREGS      = 8,
   parameter int PC_W       = 8,
   parameter int DMEM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              reset,
   mcpu_if.master            imem,
   output logic              halted,
   output logic              retire,
   output logic [2:0]        state_dbg,
   output logic [PC_W-1:0]   pc_dbg,
   output logic [15:0]       ir_dbg,
   output logic              wb_we_dbg,
   output logic [DATA_W-1:0] wb_data_dbg
);

   localparam int RIDX_W  = $clog2(NREGS);
   localparam int DADDR_W = $clog2(DMEM_DEPTH);

   mcpu_state_e       state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [IR_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0] alu_out_q, alu_out_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];

   logic [3:0]         op;
   logic [RIDX_W-1:0]  rd_idx, rs_idx, rt_idx;
   logic [DATA_W-1:0]  rd_val, rs_val, rt_val, alu_res, wb_data;
   logic               alu_valid, rf_we, dmem_we;
   logic [DADDR_W-1:0] dmem_addr;

   assign op        = ir_q[OP_LSB +: FIELD_W];
   assign rd_idx    = ir_q[RD_LSB +: RIDX_W];
   assign rs_idx    = ir_q[RS_LSB +: RIDX_W];
   assign rt_idx    = ir_q[RT_LSB +: RIDX_W];
   assign rd_val    = regs_q[rd_idx];
   assign rs_val    = regs_q[rs_idx];
   assign rt_val    = regs_q[rt_idx];
   assign dmem_addr = DADDR_W'(rs_val);

   mcpu_alu #(.DATA_W(DATA_W)) u_alu (
      .op           (op),
      .a            (rs_val),
      .b            (rt_val),
      .imm          (ir_q[7:0]),
      .result       (alu_res),
      .result_valid (alu_valid)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      alu_out_d = alu_out_q;
      mdr_d     = mdr_q;
      rf_we     = 1'b0;
      dmem_we   = 1'b0;
      retire    = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_d    = imem.imem_rdata;
            pc_d    = pc_q + PC_W'(1);
            state_d = S_DECODE;
         end
         S_DECODE: state_d = S_EXECUTE;
         S_EXECUTE: begin
            alu_out_d = alu_res;
            state_d   = S_MEM;
            // pc already points past this instruction, so the offset is relative to it
            if (op == OP_BEQ && rd_val == rs_val)
               pc_d = pc_q + PC_W'($signed(ir_q[RT_LSB +: FIELD_W]));
            if (op == OP_JMP)
               pc_d = ir_q[PC_W-1:0];
            if (op == OP_HALT) begin
               state_d = S_HALT;
               retire  = 1'b1;
            end
         end
         S_MEM: begin
            if (op == OP_LD)
               mdr_d = dmem_q[dmem_addr];
            dmem_we = (op == OP_ST);
            state_d = S_WB;
         end
         S_WB: begin
            rf_we   = alu_valid || (op == OP_LD);
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   assign wb_data = (op == OP_LD) ? mdr_q : alu_out_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= '0;
         ir_q      <= '0;
         alu_out_q <= '0;
         mdr_q     <= '0;
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         alu_out_q <= alu_out_d;
         mdr_q     <= mdr_d;
         if (rf_we)
            regs_q[rd_idx] <= wb_data;
      end
   end

   // DMEM contents survive reset, but a store is dropped on a reset edge
   always_ff @(posedge clk) begin
      if (!reset && dmem_we)
         dmem_q[dmem_addr] <= rt_val;
   end

   assign imem.imem_addr = pc_q;
   assign halted         = (state_q == S_HALT);
   assign state_dbg      = state_q;
   assign pc_dbg         = pc_q;
   assign ir_dbg         = ir_q;
   assign wb_we_dbg      = rf_we;
   assign wb_data_dbg    = rf_we ? wb_data : '0;

endmodule

// File: tb/tb_mcpu_core.sv
// Scoreboard bench for mcpu_core: an ISA-level model predicts every retirement, a monitor checks them.
module tb_mcpu_core;
   import mcpu_pkg::*;

   localparam int DATA_W     = 16;
   localparam int NREGS      = 8;
   localparam int PC_W       = 8;
   localparam int DMEM_DEPTH = 256;

   typedef struct {
      logic [15:0] ir;
      logic [7:0]  pc;
      logic        we;
      logic [15:0] data;
      int          len;
   } exp_t;

   exp_t exp_q[$];

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        halted, retire, wb_we_dbg;
   logic [2:0]  state_dbg;
   logic [7:0]  pc_dbg;
   logic [15:0] ir_dbg, wb_data_dbg;
   logic [15:0] rom [256];

   int checks   = 0;
   int failures = 0;

   logic [15:0] m_reg [NREGS];
   logic [15:0] m_mem [DMEM_DEPTH];
   logic [7:0]  m_pc;
   bit          m_halted;

   mcpu_if #(.PC_W(PC_W)) imem_bus();
   assign imem_bus.imem_rdata = rom[imem_bus.imem_addr];

   mcpu_core #(.DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W), .DMEM_DEPTH(DMEM_DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem        (imem_bus),
      .halted      (halted),
      .retire      (retire),
      .state_dbg   (state_dbg),
      .pc_dbg      (pc_dbg),
      .ir_dbg      (ir_dbg),
      .wb_we_dbg   (wb_we_dbg),
      .wb_data_dbg (wb_data_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt);
      return {op, rd, rs, rt};
   endfunction

   function automatic logic [15:0] ldi(input logic [3:0] rd, input logic [7:0] imm);
      return {4'h6, rd, imm};
   endfunction

   // ISA-level reference: one call executes one whole instruction
   task automatic model_step();
      logic [15:0] w;
      int unsigned a, b, v;
      int rd, rs, rt, off;
      exp_t e;
      w = rom[m_pc];
      m_pc = m_pc + 8'd1;
      rd = int'(w[11:8]) % NREGS;
      rs = int'(w[7:4]) % NREGS;
      rt = int'(w[3:0]) % NREGS;
      a = m_reg[rs];
      b = m_reg[rt];
      v = 0;
      e.ir = w; e.we = 1'b0; e.data = '0; e.len = 5;
      case (w[15:12])
         4'h1: begin e.we = 1'b1; v = a + b; end
         4'h2: begin e.we = 1'b1; v = a - b; end
         4'h3: begin e.we = 1'b1; v = a & b; end
         4'h4: begin e.we = 1'b1; v = a | b; end
         4'h5: begin e.we = 1'b1; v = a ^ b; end
         4'h6: begin e.we = 1'b1; v = w[7:0]; end
         4'h7: begin e.we = 1'b1; v = m_mem[a % DMEM_DEPTH]; end
         4'h8: m_mem[a % DMEM_DEPTH] = m_reg[rt];
         4'h9: if (m_reg[rd] == m_reg[rs]) begin
                  off = (w[3] == 1'b1) ? int'(w[3:0]) - 16 : int'(w[3:0]);
                  m_pc = m_pc + 8'(off);
               end
         4'hA: m_pc = w[7:0];
`ifdef MCPU_MUL_EN
         4'hB: begin e.we = 1'b1; v = a * b; end
`endif
         4'hF: begin m_halted = 1'b1; e.len = 3; end
         default: ;
      endcase
      if (e.we) begin
         e.data = v[15:0];
         m_reg[rd] = v[15:0];
      end
      e.pc = m_pc;
      exp_q.push_back(e);
   endtask

   task automatic run_model(input int max_instr, output int n);
      for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
      m_pc = '0;
      m_halted = 1'b0;
      n = 0;
      while (!m_halted && n < max_instr) begin
         model_step();
         n++;
      end
   endtask

   // Monitor: consumes one expectation per retire pulse
   int cyc = 0;
   always @(negedge clk) begin
      exp_t e;
      if (reset) cyc = 0;
      else begin
         cyc++;
         if (retire) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_retire: ir 0x%0h pc 0x%0h with nothing expected", ir_dbg, pc_dbg);
            end else begin
               e = exp_q.pop_front();
               check("retire_ir", ir_dbg, e.ir);
               check("retire_pc", pc_dbg, e.pc);
               check("retire_we", wb_we_dbg, e.we);
               if (e.we) check("retire_wdata", wb_data_dbg, e.data);
               check("retire_cycles", cyc, e.len);
               check("retire_state", state_dbg, (e.len == 3) ? 3'd2 : 3'd4);
            end
            cyc = 0;
         end
      end
   end

   task automatic apply_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", state_dbg, 3'd0);
      check("rst_pc", pc_dbg, 8'd0);
      check("rst_ir", ir_dbg, 16'd0);
      check("rst_halted", halted, 1'b0);
      check("rst_retire", retire, 1'b0);
      check("rst_we", wb_we_dbg, 1'b0);
      check("rst_wdata", wb_data_dbg, 16'd0);
      exp_q.delete();
   endtask

   task automatic run_program(input int max_instr);
      int n, budget;
      apply_reset();
      run_model(max_instr, n);
      reset = 1'b0;
      budget = n * 5 + 20;
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      check("drain_pending", exp_q.size(), 0);
      if (m_halted) begin
         repeat (4) @(posedge clk);
         #1;
         check("halt_flag", halted, 1'b1);
         check("halt_pc", pc_dbg, m_pc);
         check("halt_state", state_dbg, 3'd5);
         check("halt_retire", retire, 1'b0);
      end
      reset = 1'b1;
      exp_q.delete();
   endtask

   // Runs n_before instructions, then asserts reset while the next one sits in state st
   task automatic run_abort(input int n_before, input logic [2:0] st);
      int n, budget;
      apply_reset();
      run_model(n_before, n);
      reset = 1'b0;
      budget = 200;
      while (!(exp_q.size() == 0 && state_dbg == st) && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      check("abort_reached", (budget > 0), 1'b1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_pc", pc_dbg, 8'd0);
      check("abort_state", state_dbg, 3'd0);
      check("abort_we", wb_we_dbg, 1'b0);
      exp_q.delete();
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
   endtask

   initial begin
      clear_rom();

      // Fill all of DMEM with DMEM[a] = a so later loads are deterministic
      rom[0] = ldi(1, 8'h00);
      rom[1] = ldi(2, 8'h01);
      rom[2] = ldi(5, 8'h80);
      rom[3] = ins(4'h1, 5, 5, 5);
      rom[4] = ins(4'h8, 0, 1, 1);
      rom[5] = ins(4'h1, 1, 1, 2);
      rom[6] = ins(4'h9, 1, 5, 1);
      rom[7] = ins(4'hA, 0, 0, 4);
      run_program(2000);

      clear_rom();
      rom[0] = ldi(1, 8'd20);
      rom[1] = ldi(2, 8'd30);
      rom[2] = ins(4'h1, 5, 1, 2);
      rom[3] = ins(4'h2, 6, 5, 1);
      rom[4] = ldi(3, 8'd0);
      rom[5] = ldi(4, 8'd1);
      rom[6] = ins(4'h2, 3, 3, 4);
      rom[7] = ins(4'h2, 3, 3, 4);
      run_program(50);

      clear_rom();
      rom[0] = ldi(1, 8'd7);
      rom[1] = ldi(2, 8'hAB);
      rom[2] = ins(4'h8, 0, 1, 2);
      rom[3] = ins(4'h7, 3, 1, 0);
      run_program(50);

      clear_rom();
      rom[0] = ldi(1, 8'd3);
      rom[1] = ldi(2, 8'd1);
      rom[2] = ldi(3, 8'd0);
      rom[3] = ins(4'h2, 1, 1, 2);
      rom[4] = ins(4'h9, 1, 3, 1);
      rom[5] = ins(4'hA, 0, 0, 3);
      rom[6] = 16'hF000;
      run_program(100);

      clear_rom();
      rom[0] = ldi(1, 8'd7);
      rom[1] = ldi(2, 8'd9);
      rom[2] = ins(4'hB, 3, 1, 2);
      rom[3] = ldi(4, 8'h80);
      rom[4] = ins(4'h1, 4, 4, 4);
      rom[5] = ldi(5, 8'h11);
      rom[6] = ins(4'hB, 5, 4, 4);
      rom[7] = ins(4'h1, 6, 3, 0);
      rom[8] = ins(4'h1, 7, 5, 0);
      run_program(50);

      clear_rom();
      rom[0] = ldi(1, 8'd20);
      rom[1] = ldi(2, 8'd30);
      rom[2] = ins(4'h1, 5, 1, 2);
      run_abort(2, 3'd4);
      clear_rom();
      rom[0] = ldi(1, 8'd1);
      rom[1] = ins(4'h1, 6, 5, 1);
      run_program(50);

      clear_rom();
      rom[0] = ldi(1, 8'd9);
      rom[1] = ldi(2, 8'h55);
      rom[2] = ins(4'h8, 0, 1, 2);
      run_abort(2, 3'd3);
      clear_rom();
      rom[0] = ldi(1, 8'd9);
      rom[1] = ins(4'h7, 3, 1, 0);
      run_program(50);

      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
         run_program(150);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
